// File: rtl/argon_regfile_pkg.sv
// Shared constants and types for the Argon register file and its ALU/bus neighbours.
package argon_regfile_pkg;

  localparam int unsigned WORDSIZE = 16;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_F    = 15;
  localparam int unsigned IDXW     = $clog2(NUM_REGS);

  typedef logic [IDXW-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    WSEL_NONE = 2'd0,
    WSEL_REGC = 2'd1,
    WSEL_REGF = 2'd2
  } write_sel_t;

  localparam logic [7:0] COM_NOP    = 8'h00;
  localparam logic [7:0] COM_SELA   = 8'h01;
  localparam logic [7:0] COM_SELB   = 8'h02;
  localparam logic [7:0] COM_SELC   = 8'h03;
  localparam logic [7:0] COM_LOADC  = 8'h04;
  localparam logic [7:0] COM_READC  = 8'h05;
  localparam logic [7:0] COM_WRITEC = 8'h06;
  localparam logic [7:0] COM_WRITEF = 8'h07;

endpackage

// File: rtl/argon_regfile_storage.sv
// Register array: async read ports for A, B and C, a fixed flags tap, two sync write ports.
// R0 has no storage and always reads zero; write port 0 wins over port 1 on the same index.
module argon_regfile_storage #(
  parameter int unsigned Width   = 16,
  parameter int unsigned NumRegs = 16,
  parameter int unsigned RegF    = 15,
  parameter int unsigned IdxW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IdxW-1:0] raddr_a,
  input  logic [IdxW-1:0] raddr_b,
  input  logic [IdxW-1:0] raddr_c,
  output logic [Width-1:0] rdata_a,
  output logic [Width-1:0] rdata_b,
  output logic [Width-1:0] rdata_c,
  output logic [Width-1:0] flags,
  input  logic            we0,
  input  logic [IdxW-1:0] waddr0,
  input  logic [Width-1:0] wdata0,
  input  logic            we1,
  input  logic [IdxW-1:0] waddr1,
  input  logic [Width-1:0] wdata1
);

  logic [Width-1:0] regs_q [1:NumRegs-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NumRegs; i++) begin
        if (we0 && (waddr0 == IdxW'(i))) begin
          regs_q[i] <= wdata0;
        end else if (we1 && (waddr1 == IdxW'(i))) begin
          regs_q[i] <= wdata1;
        end
      end
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    rdata_c = '0;
    for (int i = 1; i < NumRegs; i++) begin
      if (raddr_a == IdxW'(i)) rdata_a = regs_q[i];
      if (raddr_b == IdxW'(i)) rdata_b = regs_q[i];
      if (raddr_c == IdxW'(i)) rdata_c = regs_q[i];
    end
  end

  assign flags = regs_q[RegF];

endmodule

// File: rtl/argon_regfile.sv
// Argon register file: bus command decode, ALU commit tracking and the C-register read handshake.
module argon_regfile
  import argon_regfile_pkg::*;
(
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic [7:0]          i_command,
  input  logic                i_valid,
  input  logic [WORDSIZE-1:0] i_data,
  output logic [WORDSIZE-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WORDSIZE-1:0] o_reg_a,
  output logic [WORDSIZE-1:0] o_reg_b,
  output logic [WORDSIZE-1:0] o_reg_flags,
  input  logic [WORDSIZE-1:0] i_write_data,
  input  write_sel_t          i_write_select
);

  reg_idx_t            sel_a_q, sel_b_q, sel_c_q;
  logic                commit_pend_q;
  logic                commit_we, load_we, read_go;
  reg_idx_t            commit_addr;
  logic [WORDSIZE-1:0] rdata_c;

  // The ALU's select/data lines are stale unless a commit is pending.
  always_comb begin
    commit_we   = 1'b0;
    commit_addr = sel_c_q;
    if (commit_pend_q) begin
      case (i_write_select)
        WSEL_REGC: commit_we = 1'b1;
        WSEL_REGF: begin
          commit_we   = 1'b1;
          commit_addr = reg_idx_t'(REG_F);
        end
        default: ;
      endcase
    end
  end

  assign load_we = i_valid && (i_command == COM_LOADC);
  assign read_go = i_valid && (i_command == COM_READC) && !o_valid;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sel_a_q       <= '0;
      sel_b_q       <= '0;
      sel_c_q       <= '0;
      commit_pend_q <= 1'b0;
      o_data        <= '0;
      o_valid       <= 1'b0;
    end else begin
      commit_pend_q <= (i_command == COM_WRITEC) || (i_command == COM_WRITEF);
      if (i_valid) begin
        case (i_command)
          COM_SELA: sel_a_q <= i_data[IDXW-1:0];
          COM_SELB: sel_b_q <= i_data[IDXW-1:0];
          COM_SELC: sel_c_q <= i_data[IDXW-1:0];
          default: ;
        endcase
      end
      if (read_go) begin
        o_data  <= rdata_c;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  // Port 0 carries the ALU commit so it wins a collision with a bus load.
  argon_regfile_storage #(
    .Width  (WORDSIZE),
    .NumRegs(NUM_REGS),
    .RegF   (REG_F),
    .IdxW   (IDXW)
  ) u_storage (
    .clk    (i_Clk),
    .rst    (i_Reset),
    .raddr_a(sel_a_q),
    .raddr_b(sel_b_q),
    .raddr_c(sel_c_q),
    .rdata_a(o_reg_a),
    .rdata_b(o_reg_b),
    .rdata_c(rdata_c),
    .flags  (o_reg_flags),
    .we0    (commit_we),
    .waddr0 (commit_addr),
    .wdata0 (i_write_data),
    .we1    (load_we),
    .waddr1 (sel_c_q),
    .wdata1 (i_data)
  );

endmodule
